// File: rtl/uart_frame_sched_if.sv
// uart_frame_sched_if: handshake bundle between the scan controller, the
// frame scheduler and the UART TX core. The slave modport is the scheduler's
// view. The master modport is the view of the surrounding environment, which
// drives the scan side and the UART idle flag.
interface uart_frame_sched_if;
  // Scan controller side
  logic        frame_start;
  logic        frame_end;
  logic        sample_valid;
  logic [31:0] adc_data;
  logic        sample_ready;
  // UART TX core side
  logic        tx_empty;
  logic        ld_tx_data;
  logic [7:0]  tx_data;
  logic        tx_enable;
  // Status
  logic        busy;
  logic        send_done;
  logic        frame_err;

  modport master (
    output frame_start, frame_end, sample_valid, adc_data, tx_empty,
    input  sample_ready, ld_tx_data, tx_data, tx_enable, busy, send_done,
           frame_err
  );

  modport slave (
    input  frame_start, frame_end, sample_valid, adc_data, tx_empty,
    output sample_ready, ld_tx_data, tx_data, tx_enable, busy, send_done,
           frame_err
  );
endinterface

// File: rtl/uart_frame_sched.sv
// uart_frame_sched: sequences the UART transmitter for one scan frame.
// Frame layout: HEAD_COUNT x HEAD_BYTE, BYTES_PER_SAMPLE bytes per sample
// (MSB first, HEAD_BYTE escaped to HEAD_BYTE-1), optional checksum, TAIL_BYTE.
// Define UART_FRAME_CHECKSUM_EN to add the XOR checksum byte before the tail.
module uart_frame_sched #(
  parameter int          BYTES_PER_SAMPLE = 3,
  parameter logic [7:0]  HEAD_BYTE        = 8'hFF,
  parameter int          HEAD_COUNT       = 2,
  parameter logic [7:0]  TAIL_BYTE        = 8'h0A
) (
  input  logic               clock,
  input  logic               reset,
  uart_frame_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, HEAD, DATA, TAIL, TX_LOAD, TX_GUARD, TX_WAIT
`ifdef UART_FRAME_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  localparam logic [2:0] HEAD_LAST = 3'(HEAD_COUNT);
  localparam logic [1:0] BYTE_LAST = 2'(BYTES_PER_SAMPLE - 1);

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;        // state to resume after a byte is sent
  logic [7:0]  tx_data_q, tx_data_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic [1:0]  byte_idx_q;
  logic [31:0] buf_q;
  logic        buf_full_q;
  logic        pend_end_q;
  logic        frame_err_q;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        busy;
  logic        ld_strobe;
  logic        accept;
  logic        data_exit;
  logic [7:0]  cur_byte;

  // Data bytes equal to the header value are bumped down by one so the
  // receiver can always find the header.
  function automatic logic [7:0] esc(input logic [7:0] b);
    return (b == HEAD_BYTE) ? HEAD_BYTE - 8'd1 : b;
  endfunction

  assign busy      = (state_q != IDLE);
  assign ld_strobe = (state_q == TX_LOAD) && bus.tx_empty;
  assign accept    = bus.sample_valid && busy && !buf_full_q;
  assign data_exit = (state_q == DATA) && !buf_full_q && pend_end_q;
  // byte_idx 0 selects [31:24], 1 selects [23:16], and so on
  assign cur_byte  = buf_q[{~byte_idx_q, 3'b000} +: 8];

  assign bus.busy         = busy;
  assign bus.tx_enable    = busy;
  assign bus.sample_ready = busy && !buf_full_q;
  assign bus.ld_tx_data   = ld_strobe;
  assign bus.tx_data      = tx_data_q;
  assign bus.send_done    = (state_q == TX_WAIT) && bus.tx_empty && (ret_q == IDLE);
  assign bus.frame_err    = frame_err_q;

  // Next-state logic: each byte-producing state stages tx_data, records its
  // return state and hands off to the shared load/guard/wait sub-sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    ret_d     = ret_q;
    tx_data_d = tx_data_q;
    hdr_cnt_d = hdr_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d   = HEAD;
          hdr_cnt_d = 3'd0;
        end
      end
      HEAD: begin
        if (hdr_cnt_q == HEAD_LAST) begin
          state_d = DATA;
        end else begin
          tx_data_d = HEAD_BYTE;
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          ret_d     = HEAD;
          state_d   = TX_LOAD;
        end
      end
      DATA: begin
        if (buf_full_q) begin
          tx_data_d = esc(cur_byte);
          ret_d     = DATA;
          state_d   = TX_LOAD;
        end else if (pend_end_q) begin
`ifdef UART_FRAME_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = TAIL;
`endif
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      CSUM: begin
        tx_data_d = esc(csum_q);
        ret_d     = TAIL;
        state_d   = TX_LOAD;
      end
`endif
      TAIL: begin
        tx_data_d = TAIL_BYTE;
        ret_d     = IDLE;
        state_d   = TX_LOAD;
      end
      TX_LOAD:  if (bus.tx_empty) state_d = TX_GUARD;
      TX_GUARD: state_d = TX_WAIT;
      TX_WAIT:  if (bus.tx_empty) state_d = ret_q;
      default:  state_d = IDLE;
    endcase
  end

  // FSM registers and the staged output byte
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of block ordering.
    if (reset) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      tx_data_q <= 8'h00;
      hdr_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      tx_data_q <= tx_data_d;
      hdr_cnt_q <= hdr_cnt_d;
    end
  end

  // Sample holding register: filled on handshake, released when the UART
  // takes the last byte of the sample, not when that byte is staged.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the data word is reset along with its valid flag; it is a
      // single register, so the cost is negligible and X never escapes.
      buf_q      <= 32'h0;
      buf_full_q <= 1'b0;
      byte_idx_q <= 2'd0;
    end else begin
      if (ld_strobe && ret_q == DATA) begin
        if (byte_idx_q == BYTE_LAST) begin
          byte_idx_q <= 2'd0;
          buf_full_q <= 1'b0;
        end else begin
          byte_idx_q <= byte_idx_q + 2'd1;
        end
      end
      if (accept) begin
        buf_q      <= bus.adc_data;
        buf_full_q <= 1'b1;
      end
    end
  end

  // Pending-end flag: remembers frame_end until the buffer has drained
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_end_q <= 1'b0;
    end else if (!busy) begin
      pend_end_q <= 1'b0;
    end else if (bus.frame_end) begin
      pend_end_q <= 1'b1;
    end else if (data_exit) begin
      pend_end_q <= 1'b0;
    end
  end

  // Sticky protocol error: frame_start while busy or frame_end while idle
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_err_q <= 1'b0;
    end else if ((bus.frame_start && busy) || (bus.frame_end && !busy)) begin
      frame_err_q <= 1'b1;
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  // XOR of every transmitted data byte (post-escape); cleared when a frame opens
  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else if (state_q == IDLE && bus.frame_start) begin
      csum_q <= 8'h00;
    end else if (ld_strobe && ret_q == DATA) begin
      csum_q <= csum_q ^ tx_data_q;
    end
  end
`endif

endmodule

// File: tb/tb_uart_frame_sched.sv
// tb_uart_frame_sched: directed test of uart_frame_sched. A negedge monitor
// logs every byte handed to the UART; a small UART model can hold tx_empty
// low for 20 cycles after each load.
module tb_uart_frame_sched;

  logic clock;
  logic reset;
  uart_frame_sched_if bus ();

  uart_frame_sched dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] byte_q[$];
  int         done_cnt   = 0;
  int         bad_strobe = 0;
  logic       slow_mode  = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Byte log and strobe monitor, sampled away from the active edge
  always @(negedge clock) begin
    if (bus.ld_tx_data) byte_q.push_back(bus.tx_data);
    if (bus.send_done) done_cnt++;
    if (bus.ld_tx_data && !bus.tx_empty) bad_strobe++;
  end

  // UART model: idle unless slow_mode, then busy for 20 cycles after a load
  initial begin
    bus.tx_empty = 1'b1;
    forever begin
      @(negedge clock);
      if (slow_mode && bus.ld_tx_data) begin
        @(posedge clock);
        #1 bus.tx_empty = 1'b0;
        repeat (20) @(posedge clock);
        #1 bus.tx_empty = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] e[$]);
    check({tag, "_len"}, byte_q.size(), e.size());
    for (int i = 0; i < e.size() && i < byte_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), {24'h0, byte_q[i]}, {24'h0, e[i]});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, bus.sample_ready, 0);
    check({tag, "_ld"},    bus.ld_tx_data, 0);
    check({tag, "_data"},  bus.tx_data, 0);
    check({tag, "_en"},    bus.tx_enable, 0);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_done"},  bus.send_done, 0);
    check({tag, "_err"},   bus.frame_err, 0);
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  // Present a sample (sample_valid stays high afterwards); reports the
  // number of bytes already loaded when the DUT became ready for it.
  task automatic offer(input string tag, input logic [31:0] d, input logic last,
                       output int loaded_at_accept);
    bus.sample_valid = 1'b1;
    bus.adc_data     = d;
    for (int i = 0; i < 2000 && !bus.sample_ready; i++) tick();
    check({tag, "_ready"}, bus.sample_ready, 1);
    loaded_at_accept = byte_q.size();
    bus.frame_end = last;
    tick();
    bus.frame_end = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && bus.busy; i++) tick();
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    logic [7:0] e[$];
    int         n_loaded;

    reset            = 1'b1;
    bus.frame_start  = 1'b0;
    bus.frame_end    = 1'b0;
    bus.sample_valid = 1'b0;
    bus.adc_data     = 32'h0;
    repeat (3) tick();
    check_idle_outputs("rst");
    reset = 1'b0;
    tick();

    // Frame 1: one sample, frame_end with the sample, latency check
    byte_q.delete(); done_cnt = 0;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check("f1_busy_head", bus.busy, 1);
    check("f1_en_head", bus.tx_enable, 1);
    check("f1_ld_early", bus.ld_tx_data, 0);
    bus.sample_valid = 1'b1;
    bus.adc_data     = 32'h12345600;
    bus.frame_end    = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    bus.frame_end    = 1'b0;
    check("f1_ld_lat2", bus.ld_tx_data, 1);
    check("f1_data_lat2", bus.tx_data, 8'hFF);
    wait_done("f1");
    e = '{8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56};
`ifdef UART_FRAME_CHECKSUM_EN
    e.push_back(8'h70);
`endif
    e.push_back(8'h0A);
    check_bytes("f1", e);
    check("f1_done_cnt", done_cnt, 1);
    check("f1_err", bus.frame_err, 0);

    // Frame 2: escape rule
    byte_q.delete(); done_cnt = 0;
    start_frame();
    offer("f2", 32'hFF00FF00, 1'b1, n_loaded);
    bus.sample_valid = 1'b0;
    wait_done("f2");
    e = '{8'hFF, 8'hFF, 8'hFE, 8'h00, 8'hFE};
`ifdef UART_FRAME_CHECKSUM_EN
    e.push_back(8'h00);
`endif
    e.push_back(8'h0A);
    check_bytes("f2", e);
    check("f2_done_cnt", done_cnt, 1);

    // Frame 3: slow UART, one strobe per byte, none while tx_empty low
    byte_q.delete(); done_cnt = 0; bad_strobe = 0;
    slow_mode = 1'b1;
    start_frame();
    offer("f3", 32'hA1B2C3D4, 1'b1, n_loaded);
    bus.sample_valid = 1'b0;
    wait_done("f3");
    slow_mode = 1'b0;
    e = '{8'hFF, 8'hFF, 8'hA1, 8'hB2, 8'hC3};
`ifdef UART_FRAME_CHECKSUM_EN
    e.push_back(8'hD0);
`endif
    e.push_back(8'h0A);
    check_bytes("f3", e);
    check("f3_done_cnt", done_cnt, 1);
    check("f3_bad_strobe", bad_strobe, 0);
    repeat (25) tick();

    // Frame 4: zero samples; checksum must have been cleared
    byte_q.delete(); done_cnt = 0;
    start_frame();
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    wait_done("f4");
    e = '{8'hFF, 8'hFF};
`ifdef UART_FRAME_CHECKSUM_EN
    e.push_back(8'h00);
`endif
    e.push_back(8'h0A);
    check_bytes("f4", e);
    check("f4_done_cnt", done_cnt, 1);

    // Frame 5: back-to-back samples with sample_valid held high
    byte_q.delete(); done_cnt = 0;
    start_frame();
    offer("f5a", 32'h01020304, 1'b0, n_loaded);
    offer("f5b", 32'h0A0B0C0D, 1'b1, n_loaded);
    bus.sample_valid = 1'b0;
    check("f5_second_accept_after", n_loaded, 5);
    wait_done("f5");
    e = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'h0C};
`ifdef UART_FRAME_CHECKSUM_EN
    e.push_back(8'h0D);
`endif
    e.push_back(8'h0A);
    check_bytes("f5", e);
    check("f5_done_cnt", done_cnt, 1);

    // frame_end while idle is ignored but flagged
    byte_q.delete();
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    tick();
    check("idle_end_err", bus.frame_err, 1);
    check("idle_end_busy", bus.busy, 0);
    check("idle_end_nobytes", byte_q.size(), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("err_cleared", bus.frame_err, 0);

    // frame_start while busy, then reset mid-DATA
    start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check("dup_start_err", bus.frame_err, 1);
    offer("f6", 32'h11223344, 1'b0, n_loaded);
    bus.sample_valid = 1'b0;
    repeat (10) tick();
    check("f6_busy_mid", bus.busy, 1);
    reset = 1'b1;
    tick();
    check_idle_outputs("midrst");
    reset = 1'b0;
    tick();

    // Clean frame after reset
    byte_q.delete(); done_cnt = 0;
    start_frame();
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    wait_done("f7");
    e = '{8'hFF, 8'hFF};
`ifdef UART_FRAME_CHECKSUM_EN
    e.push_back(8'h00);
`endif
    e.push_back(8'h0A);
    check_bytes("f7", e);
    check("f7_done_cnt", done_cnt, 1);
    check("f7_err", bus.frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
